// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered WIDTH:1 bit selector with manual index and timed scan modes
// Define SCAN_MUX_SYNC_EN to route data through a two-flop synchroniser before selection.
module scan_mux #(
   parameter int WIDTH     = 32,
   parameter int LOG_WIDTH = 5,
   parameter int DWELL_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     data,
   input  logic [LOG_WIDTH-1:0] sel,
   input  logic                 sel_valid,
   input  logic                 mode,
   input  logic [DWELL_W-1:0]   dwell,
   output logic                 out,
   output logic [LOG_WIDTH-1:0] out_idx,
   output logic                 out_valid,
   output logic                 wrap,
   output logic                 err
);

   localparam int                   PAD_W    = 1 << LOG_WIDTH;
   localparam logic [LOG_WIDTH:0]   WIDTH_L  = (LOG_WIDTH + 1)'(WIDTH);
   localparam logic [LOG_WIDTH-1:0] LAST_IDX = LOG_WIDTH'(WIDTH - 1);
   localparam logic [LOG_WIDTH-1:0] ONE_IDX  = LOG_WIDTH'(1);
   localparam logic [DWELL_W-1:0]   ONE_CNT  = DWELL_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t               state_q, state_n;
   logic [LOG_WIDTH-1:0] idx_n;
   logic [DWELL_W-1:0]   count_q, count_n;
   logic                 wrap_n, err_n;
   logic                 sel_ok;
   logic [WIDTH-1:0]     data_s;
   logic [PAD_W-1:0]     data_pad;

`ifdef SCAN_MUX_SYNC_EN
   logic [WIDTH-1:0] sync_q1, sync_q2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= data;
         sync_q2 <= sync_q1;
      end
   end

   assign data_s = sync_q2;
`else
   assign data_s = data;
`endif

   // Padding to a power of two keeps the variable bit-select in range for any WIDTH.
   assign data_pad = PAD_W'(data_s);
   assign sel_ok   = {1'b0, sel} < WIDTH_L;

   always_comb begin
      state_n = state_q;
      idx_n   = out_idx;
      count_n = count_q;
      wrap_n  = 1'b0;
      err_n   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mode) begin
               state_n = SCAN;
               idx_n   = '0;
               count_n = '0;
            end else if (sel_valid && sel_ok) begin
               state_n = MANUAL;
               idx_n   = sel;
            end
         end
         MANUAL: begin
            if (mode) begin
               state_n = SCAN;
               idx_n   = '0;
               count_n = '0;
            end else if (sel_valid) begin
               if (sel_ok) begin
                  idx_n = sel;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         SCAN: begin
            if (!mode) begin
               state_n = MANUAL;
               count_n = '0;
               if (sel_valid) begin
                  if (sel_ok) begin
                     idx_n = sel;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end else if (count_q >= dwell) begin
               // >= rather than == so a dwell lowered below the running count steps at once.
               count_n = '0;
               wrap_n  = (out_idx == LAST_IDX);
               idx_n   = (out_idx == LAST_IDX) ? '0 : out_idx + ONE_IDX;
            end else begin
               count_n = count_q + ONE_CNT;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
            count_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         out_idx   <= '0;
         count_q   <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_n;
         out_idx   <= idx_n;
         count_q   <= count_n;
         out       <= (state_n != IDLE) ? data_pad[idx_n] : 1'b0;
         out_valid <= (state_n != IDLE);
         wrap      <= wrap_n;
         err       <= err_n;
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed bench for scan_mux at WIDTH=32 and WIDTH=20
// Build with SCAN_MUX_SYNC_EN defined to exercise the synchronised data path.
module tb_scan_mux;

`ifdef SCAN_MUX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] data32;
   logic [19:0] data20;
   logic [4:0]  sel;
   logic        sel_valid;
   logic        mode;
   logic [7:0]  dwell;

   logic        o32, v32, w32, e32;
   logic [4:0]  idx32;
   logic        o20, v20, w20, e20;
   logic [4:0]  idx20;

   int n_cmp = 0;
   int n_bad = 0;

   assign data20 = data32[19:0];

   scan_mux #(.WIDTH(32), .LOG_WIDTH(5), .DWELL_W(8)) u_dut32 (
      .clk(clk), .reset(reset), .data(data32), .sel(sel), .sel_valid(sel_valid),
      .mode(mode), .dwell(dwell), .out(o32), .out_idx(idx32), .out_valid(v32),
      .wrap(w32), .err(e32)
   );

   scan_mux #(.WIDTH(20), .LOG_WIDTH(5), .DWELL_W(8)) u_dut20 (
      .clk(clk), .reset(reset), .data(data20), .sel(sel), .sel_valid(sel_valid),
      .mode(mode), .dwell(dwell), .out(o20), .out_idx(idx20), .out_valid(v20),
      .wrap(w20), .err(e20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ei;
      reset     = 1'b1;
      data32    = 32'hA5A5_0F0F;
      sel       = '0;
      sel_valid = 1'b0;
      mode      = 1'b0;
      dwell     = '0;
      #2;
      check("rst_out", o32, 0);
      check("rst_idx", idx32, 0);
      check("rst_valid", v32, 0);
      check("rst_wrap", w32, 0);
      check("rst_err", e32, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      repeat (3) begin
         tick();
         check("idle_valid", v32, 0);
         check("idle_out", o32, 0);
      end

      // manual loads against 0xA5A5_0F0F: bit4=0, bit8=1, bit31=1
      sel = 5'd4; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
      check("man4_out", o32, 0);
      check("man4_idx", idx32, 4);
      check("man4_valid", v32, 1);
      sel = 5'd8; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
      check("man8_out", o32, 1);
      check("man8_idx", idx32, 8);
      sel = 5'd31; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
      check("man31_out", o32, 1);
      check("man31_idx", idx32, 31);
      check("man31_err32", e32, 0);
      check("oor31_err20", e20, 1);
      check("oor31_idx20", idx20, 8);
      tick();
      check("oor31_err_clr", e20, 0);

      sel = 5'd3; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
      check("man3_idx20", idx20, 3);
      sel = 5'd25; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
      check("oor25_err20", e20, 1);
      check("oor25_idx20", idx20, 3);
      check("man25_idx32", idx32, 25);
      check("man25_out32", o32, 0);
      check("man25_err32", e32, 0);
      tick();
      check("oor25_err_clr", e20, 0);
      check("oor25_idx_hold", idx20, 3);

      // data[7] 0->1 with idx fixed at 7
      sel = 5'd7; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
      check("d7_before", o32, 0);
      data32 = 32'hA5A5_0F8F;
      for (int i = 1; i < LAT; i++) begin
         tick();
         check("d7_hold", o32, 0);
      end
      tick();
      check("d7_rise", o32, 1);

      // scan dwell=2 with sel_valid coinciding with entry; sel_valid stays high and must be ignored
      data32 = 32'h0000_0001;
      repeat (LAT) tick();
      mode = 1'b1; dwell = 8'd2; sel = 5'd5; sel_valid = 1'b1;
      tick();
      sel = 5'd25;
      check("entry_idx32", idx32, 0);
      check("entry_wrap32", w32, 0);
      check("entry_out32", o32, 1);
      check("entry_idx20", idx20, 0);
      check("entry_wrap20", w20, 0);
      for (int t = 1; t <= 100; t++) begin
         tick();
         ei = (t / 3) % 32;
         check("scan_idx32", idx32, ei);
         check("scan_out32", o32, (ei == 0) ? 1 : 0);
         check("scan_wrap32", w32, (t % 3 == 0 && ei == 0) ? 1 : 0);
         check("scan_idx20", idx20, (t / 3) % 20);
         check("scan_wrap20", w20, (t % 3 == 0 && (t / 3) % 20 == 0) ? 1 : 0);
         check("scan_err20", e20, 0);
      end
      sel_valid = 1'b0;
      mode = 1'b0;
      tick();
      check("exit_idx_held", idx32, 1);
      check("exit_valid", v32, 1);

      // dwell lowered from 9 to 3 while count=6
      mode = 1'b1; dwell = 8'd9;
      tick();
      check("dw_entry_idx", idx32, 0);
      repeat (6) tick();
      check("dw_cnt6_idx", idx32, 0);
      dwell = 8'd3;
      tick();
      check("dw_step_now", idx32, 1);
      repeat (3) begin
         tick();
         check("dw_hold", idx32, 1);
      end
      tick();
      check("dw_step4", idx32, 2);

      mode = 1'b0; sel = 5'd9; sel_valid = 1'b1;
      tick();
      sel_valid = 1'b0;
      check("exit_sel_idx", idx32, 9);

      // asynchronous reset while scanning at idx 17
      data32 = 32'hFFFF_FFFF;
      repeat (LAT) tick();
      mode = 1'b1; dwell = 8'd0;
      tick();
      check("d0_entry_idx", idx32, 0);
      repeat (17) tick();
      check("d0_idx17", idx32, 17);
      check("d0_out17", o32, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_out", o32, 0);
      check("arst_idx", idx32, 0);
      check("arst_valid", v32, 0);
      mode = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) begin
         tick();
         check("post_idle_valid", v32, 0);
         check("post_idle_idx", idx32, 0);
      end
      sel = 5'd2; sel_valid = 1'b1;
      tick();
      sel_valid = 1'b0;
      check("post_valid", v32, 1);
      check("post_idx", idx32, 2);
      check("post_out", o32, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
